fib_arb: RTL and testbench
==========================

FIB_ARB -- requirements
Module: fib_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: engine watchdog limit in cycles.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  N_REQ  per-requester request-pending flag.
REQ-006 SHALL have port req_idx  in  N_REQ x 5  per-requester Fibonacci index.
REQ-007 SHALL have port req_ready  out  N_REQ  one-hot accept pulse.
REQ-008 SHALL have port rsp_valid  out  N_REQ  one-hot response pulse.
REQ-009 SHALL have port rsp_result  out  20  result shared by all requesters.
REQ-010 SHALL have port rsp_err  out  1  error flag qualified by rsp_valid.
REQ-011 SHALL have port eng_start  out  1  one-cycle start pulse to the fib engine.
REQ-012 SHALL have port eng_i  out  5  engine index, held stable from START through WAIT.
REQ-013 SHALL have port eng_done  in  1  engine completion.
REQ-014 SHALL have port eng_result  in  20  engine result, valid while eng_done=1.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> START -> WAIT -> RESP -> IDLE.
REQ-017 IDLE: SHALL, when any req_valid=1, grant round-robin from rr_ptr upward (wrapping), pulse req_ready[owner] that cycle, latch owner and idx, then go to START.
REQ-018 IDLE: SHALL leave all outputs low and rr_ptr unchanged when no req_valid=1.
REQ-019 SHALL treat idx > 30 (result exceeds 20 bits) as invalid: IDLE -> RESP directly, rsp_err=1, rsp_result=0, engine untouched.
REQ-020 START: SHALL drive eng_start=1 for exactly one cycle, then go to WAIT.
REQ-021 WAIT: SHALL ignore eng_done in its first cycle (stale-done guard).
REQ-022 WAIT: SHALL, from the second cycle on, capture eng_result on the first cycle eng_done=1, then go to RESP.
REQ-023 RESP: SHALL drive rsp_valid[owner]=1 for one cycle with captured rsp_result and rsp_err, set rr_ptr=(owner+1) mod N_REQ, then go to IDLE.
REQ-024 SHALL hold rsp_result stable until the next RESP.
REQ-025 Latency: accept at cycle T; eng_start at T+1; rsp_valid one cycle after the eng_done capture cycle.
REQ-026 Invalid-index latency: rsp_valid at T+1.
REQ-027 SHALL, when requests are simultaneous, serve each active requester once before any is served twice.
REQ-028 SHALL sample req_valid only in IDLE; a requester dropping req_valid while not granted is simply skipped.
REQ-029 SHALL never assert more than one bit of req_ready, or of rsp_valid, in any cycle.

Reset
REQ-030 rst SHALL force state=IDLE, rr_ptr=0, rsp_result=0, and all of req_ready, rsp_valid, rsp_err, eng_start, eng_i and busy to 0 on the next clk edge.
REQ-031 Reset mid-operation SHALL drop the in-flight request with no response; the requester must re-request.

Configuration
REQ-032 With FIB_ARB_TIMEOUT_EN defined, SHALL count WAIT cycles and, after TIMEOUT_CYC cycles without a captured eng_done, go to RESP with rsp_err=1 and rsp_result=0.
REQ-033 With FIB_ARB_TIMEOUT_EN defined, a done arriving after timeout SHALL be ignored.
REQ-034 Without FIB_ARB_TIMEOUT_EN, SHALL have no timeout counter; WAIT exits only on eng_done; rsp_err is set only by REQ-019.

Structure
REQ-035 Package fib_arb_pkg SHALL hold the state enum, IDX_W=5, RES_W=20 and MAX_IDX=30.
REQ-036 Sub-module fib_rr_pick SHALL be a combinational round-robin picker: inputs req vector and rr_ptr; outputs any flag and owner index.
REQ-037 The fib engine SHALL be instantiated outside fib_arb; the bench connects the two.

Verification
REQ-038 Single request: req 0, idx=10 -> req_ready[0] at T, eng_start at T+1, rsp_valid[0] with result=55, rsp_err=0.
REQ-039 All four requesting, idx 5/6/7/8, rr_ptr=0 -> served in order 0,1,2,3; results 5, 8, 13, 21.
REQ-040 Boundary indices: idx=30 -> 832040; idx=0 -> 0; idx=31 -> rsp_err=1, result 0 at T+1, no eng_start.
REQ-041 Fairness: req 1 held continuously while req 3 pulses once -> grants alternate 1, 3, 1.
REQ-042 rst asserted during WAIT -> next cycle busy=0 and no rsp_valid; a subsequent idx=12 request returns 144.
REQ-043 FIB_ARB_TIMEOUT_EN, engine stub never asserting done -> rsp_err=1 after 64 WAIT cycles; without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/fib_arb_pkg.sv
// rtl/fib_arb_pkg.sv - shared types, widths and index limits for the Fibonacci request arbiter
package fib_arb_pkg;

    localparam int IDX_W   = 5;
    localparam int RES_W   = 20;
    localparam int MAX_IDX = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // fib(31) no longer fits in RES_W bits, so such indices never reach the engine
    function automatic logic idx_invalid(input logic [IDX_W-1:0] idx);
        return idx > IDX_W'(MAX_IDX);
    endfunction

endpackage

// File: rtl/fib_arb_if.sv
// rtl/fib_arb_if.sv - requester-side request/response bundle between clients and fib_arb
interface fib_arb_if
    import fib_arb_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][IDX_W-1:0] req_idx;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [RES_W-1:0]            rsp_result;
    logic                        rsp_err;

    modport master (
        output req_valid, req_idx,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_idx,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/fib_rr_pick.sv
// rtl/fib_rr_pick.sv - combinational round-robin picker: first set request at or above rr_ptr, wrapping
module fib_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             any,
    output logic [PTR_W-1:0] owner
);

    localparam int SW = PTR_W + 1;

    logic [PTR_W:0] sum;

    // Scan from the farthest candidate back to rr_ptr so the closest hit is written last
    always_comb begin
        any   = 1'b0;
        owner = '0;
        sum   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            if (req[sum[PTR_W-1:0]]) begin
                any   = 1'b1;
                owner = sum[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fib_arb.sv
// rtl/fib_arb.sv - round-robin arbiter sharing one external Fibonacci engine among N_REQ requesters
// Optional engine watchdog enabled by defining FIB_ARB_TIMEOUT_EN.
module fib_arb
    import fib_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    fib_arb_if.slave         bus,
    output logic             eng_start,
    output logic [IDX_W-1:0] eng_i,
    input  logic             eng_done,
    input  logic [RES_W-1:0] eng_result,
    output logic             busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW    = PTR_W + 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             pick_any;
    logic [PTR_W-1:0] pick_owner;
    logic [PTR_W:0]   owner_inc;
    logic             wait_first;

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    assign wait_first = (wait_cnt_q == '0);
`else
    logic first_q, first_d;
    assign wait_first = first_q;
`endif

    fib_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .owner  (pick_owner)
    );

    assign eng_i          = idx_q;
    assign bus.rsp_result = result_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idx_d         = idx_q;
        result_d      = result_q;
        err_d         = err_q;
        eng_start     = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_err   = 1'b0;
        busy          = (state_q != ST_IDLE);
        owner_inc     = {1'b0, owner_q} + SW'(1);
        if (owner_inc == SW'(N_REQ)) begin
            owner_inc = '0;
        end
`ifdef FIB_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`else
        first_d    = first_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any && !rst) begin
                    bus.req_ready[pick_owner] = 1'b1;
                    owner_d                   = pick_owner;
                    if (idx_invalid(bus.req_idx[pick_owner])) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        idx_d   = bus.req_idx[pick_owner];
                        err_d   = 1'b0;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                eng_start = 1'b1;
                state_d   = ST_WAIT;
`ifdef FIB_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`else
                first_d    = 1'b1;
`endif
            end
            ST_WAIT: begin
                // A done seen in the first WAIT cycle may belong to a previous job
`ifdef FIB_ARB_TIMEOUT_EN
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
`else
                first_d    = 1'b0;
`endif
                if (!wait_first && eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end
`ifdef FIB_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                bus.rsp_valid[owner_q] = 1'b1;
                bus.rsp_err            = err_q;
                rr_ptr_d               = owner_inc[PTR_W-1:0];
                state_d                = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`else
            first_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef FIB_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`else
            first_q    <= first_d;
`endif
        end
    end

endmodule

// File: tb/tb_fib_arb.sv
// tb/tb_fib_arb.sv - self-checking bench for fib_arb with directed cases and randomized requester traffic
module tb_fib_arb;
    import fib_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             eng_start;
    logic [IDX_W-1:0] eng_i;
    logic             eng_done;
    logic [RES_W-1:0] eng_result;
    logic             busy;

    fib_arb_if #(.N_REQ(N)) bus ();

    fib_arb #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .eng_start  (eng_start),
        .eng_i      (eng_i),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    int               rr_m  = 0;
    logic [RES_W-1:0] last_res = '0;
    logic [N-1:0]     pend;
    logic [4:0]       pidx [N];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] fib_ref(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a[RES_W-1:0];
    endfunction

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one = 32'd1;
        return one << i;
    endfunction

    function automatic int pick_ref(input logic [N-1:0] p, input int rr);
        for (int k = 0; k < N; k++) begin
            if (p[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.req_valid = '1;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_req_ready", bus.req_ready, 0);
        chk_eq("rst_rsp_valid", bus.rsp_valid, 0);
        chk_eq("rst_rsp_err", bus.rsp_err, 0);
        chk_eq("rst_eng_start", eng_start, 0);
        chk_eq("rst_eng_i", eng_i, 0);
        chk_eq("rst_rsp_result", bus.rsp_result, 0);
        rst = 1'b0;
        bus.req_valid = '0;
        tick;
        rr_m = 0;
        last_res = '0;
    endtask

    task automatic idle_chk;
        bus.req_valid = '0;
        @(negedge clk);
        chk_eq("idle_req_ready", bus.req_ready, 0);
        chk_eq("idle_busy", busy, 0);
        chk_eq("idle_rsp_valid", bus.rsp_valid, 0);
        tick;
    endtask

    // Caller has driven req_valid/req_idx at posedge+1 of an IDLE cycle
    task automatic serve(input int own, input logic [4:0] idx, input logic [RES_W-1:0] exp_res,
                         input bit exp_err, input int k, input bit stale);
        @(negedge clk);
        chk_eq("grant", bus.req_ready, oh(own));
        chk_eq("grant_busy", busy, 0);
        chk_eq("held_result", bus.rsp_result, last_res);
        tick;
        if (exp_err) begin
            @(negedge clk);
            chk_eq("bad_rsp_valid", bus.rsp_valid, oh(own));
            chk_eq("bad_rsp_err", bus.rsp_err, 1);
            chk_eq("bad_rsp_result", bus.rsp_result, 0);
            chk_eq("bad_no_start", eng_start, 0);
            tick;
        end else begin
            @(negedge clk);
            chk_eq("start", eng_start, 1);
            chk_eq("eng_i", eng_i, idx);
            chk_eq("start_busy", busy, 1);
            tick;
            if (stale) begin
                eng_done   = 1'b1;
                eng_result = 20'hABCDE;
            end
            @(negedge clk);
            chk_eq("wait1_quiet", bus.rsp_valid, 0);
            chk_eq("start_once", eng_start, 0);
            tick;
            eng_done = 1'b0;
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                chk_eq("wait_quiet", bus.rsp_valid, 0);
                tick;
            end
            eng_done   = 1'b1;
            eng_result = exp_res;
            tick;
            eng_done   = 1'b0;
            eng_result = 20'h5A5A5;
            @(negedge clk);
            chk_eq("rsp_valid", bus.rsp_valid, oh(own));
            chk_eq("rsp_result", bus.rsp_result, exp_res);
            chk_eq("rsp_err", bus.rsp_err, 0);
            chk_eq("eng_i_hold", eng_i, idx);
            tick;
        end
        last_res = exp_err ? '0 : exp_res;
        rr_m = (own + 1) % N;
    endtask

    initial begin
        int  o;
        bit  stuck;
        rst           = 1'b1;
        eng_done      = 1'b0;
        eng_result    = '0;
        bus.req_valid = '0;
        bus.req_idx   = '0;
        do_reset;

        // single request, idx 10
        bus.req_valid = 4'b0001;
        bus.req_idx[0] = 5'd10;
        serve(0, 5'd10, 20'd55, 0, 2, 0);
        idle_chk;

        // all four at once from rr_ptr 0
        do_reset;
        bus.req_valid = 4'b1111;
        bus.req_idx[0] = 5'd5;
        bus.req_idx[1] = 5'd6;
        bus.req_idx[2] = 5'd7;
        bus.req_idx[3] = 5'd8;
        serve(0, 5'd5, 20'd5, 0, 1, 0);
        bus.req_valid[0] = 1'b0;
        serve(1, 5'd6, 20'd8, 0, 0, 1);
        bus.req_valid[1] = 1'b0;
        serve(2, 5'd7, 20'd13, 0, 3, 0);
        bus.req_valid[2] = 1'b0;
        serve(3, 5'd8, 20'd21, 0, 0, 0);
        idle_chk;

        // boundary indices
        bus.req_valid = 4'b0001;
        bus.req_idx[0] = 5'd30;
        serve(0, 5'd30, 20'd832040, 0, 0, 1);
        bus.req_valid = 4'b0010;
        bus.req_idx[1] = 5'd0;
        serve(1, 5'd0, 20'd0, 0, 1, 0);
        bus.req_valid = 4'b0100;
        bus.req_idx[2] = 5'd31;
        serve(2, 5'd31, 20'd0, 1, 0, 0);
        idle_chk;

        // fairness: 1 held, 3 pulses once
        do_reset;
        bus.req_valid = 4'b1010;
        bus.req_idx[1] = 5'd3;
        bus.req_idx[3] = 5'd4;
        serve(1, 5'd3, 20'd2, 0, 0, 0);
        serve(3, 5'd4, 20'd3, 0, 0, 0);
        bus.req_valid[3] = 1'b0;
        serve(1, 5'd3, 20'd2, 0, 0, 0);
        idle_chk;

        // reset during WAIT drops the job
        do_reset;
        bus.req_valid = 4'b0100;
        bus.req_idx[2] = 5'd12;
        @(negedge clk);
        chk_eq("rw_grant", bus.req_ready, oh(2));
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        chk_eq("rw_busy", busy, 0);
        chk_eq("rw_rsp_valid", bus.rsp_valid, 0);
        chk_eq("rw_req_ready", bus.req_ready, 0);
        chk_eq("rw_eng_start", eng_start, 0);
        rst = 1'b0;
        bus.req_valid = '0;
        tick;
        rr_m = 0;
        last_res = '0;
        bus.req_valid = 4'b0100;
        serve(2, 5'd12, 20'd144, 0, 1, 0);
        idle_chk;

        // engine that never answers
        bus.req_valid = 4'b0001;
        bus.req_idx[0] = 5'd9;
        @(negedge clk);
        chk_eq("to_grant", bus.req_ready, oh(0));
        tick;
        bus.req_valid = '0;
        @(negedge clk);
        chk_eq("to_start", eng_start, 1);
        tick;
`ifdef FIB_ARB_TIMEOUT_EN
        for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            chk_eq("to_wait_quiet", bus.rsp_valid, 0);
            tick;
        end
        @(negedge clk);
        chk_eq("to_rsp_valid", bus.rsp_valid, oh(0));
        chk_eq("to_rsp_err", bus.rsp_err, 1);
        chk_eq("to_rsp_result", bus.rsp_result, 0);
        tick;
        eng_done   = 1'b1;
        eng_result = 20'd77;
        @(negedge clk);
        chk_eq("late_busy", busy, 0);
        chk_eq("late_rsp_valid", bus.rsp_valid, 0);
        tick;
        eng_done = 1'b0;
        @(negedge clk);
        chk_eq("late_rsp_valid2", bus.rsp_valid, 0);
        chk_eq("late_result", bus.rsp_result, 0);
        tick;
`else
        stuck = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (busy !== 1'b1 || bus.rsp_valid !== '0) stuck = 1'b1;
            tick;
        end
        chk_eq("no_timeout_busy", stuck, 0);
`endif
        do_reset;

        // randomized traffic against the round-robin reference
        pend = '0;
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pidx[i] = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
                end
            end
            if (pend != '0 && $urandom_range(0, 5) == 0) begin
                pend[$urandom_range(0, N - 1)] = 1'b0;
            end
            bus.req_valid = pend;
            for (int i = 0; i < N; i++) bus.req_idx[i] = pidx[i];
            if (pend == '0) begin
                idle_chk;
            end else begin
                o = pick_ref(pend, rr_m);
                serve(o, pidx[o], (pidx[o] > 5'd30) ? 20'd0 : fib_ref(int'(pidx[o])),
                      pidx[o] > 5'd30, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
                pend[o] = 1'b0;
                bus.req_valid = pend;
            end
        end
        idle_chk;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
